// File: rtl/trace_capture_buffer_pkg.sv
// Shared definitions for the retire-stream trace buffer: FSM encoding and
// the layout of one stored entry {pc, instr, result}.
package trace_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Field slots inside an entry, counted in DATA_W units from the LSB.
  localparam int FLD_RESULT = 0;
  localparam int FLD_INSTR  = 1;
  localparam int FLD_PC     = 2;
  localparam int NUM_FIELDS = 3;

  function automatic int entry_w(input int data_w);
    return NUM_FIELDS * data_w;
  endfunction

  function automatic int field_lsb(input int data_w, input int fld);
    return fld * data_w;
  endfunction

endpackage

// File: rtl/trace_capture_buffer_ram.sv
// Trace store: DEPTH x WIDTH register array with one synchronous write port
// and one asynchronous read port. Contents are not reset.
module trace_capture_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write one entry per accepted sample.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/trace_capture_buffer.sv
// On-chip trace of the retire stream. Keeps a circular pre-trigger history,
// stops POST_TRIG samples after a PC-match or forced trigger, then streams
// the frozen trace out oldest-first over a valid/ready port.
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cap_valid,
  input  logic [DATA_W-1:0]        cap_pc,
  input  logic [DATA_W-1:0]        cap_instr,
  input  logic [DATA_W-1:0]        cap_result,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     force_trig,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] trig_idx,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [3*DATA_W-1:0]      rd_data,
  output logic                     rd_last
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_w(DATA_W);
  localparam int PC_LSB  = field_lsb(DATA_W, FLD_PC);
  localparam int IN_LSB  = field_lsb(DATA_W, FLD_INSTR);
  localparam int RS_LSB  = field_lsb(DATA_W, FLD_RESULT);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] POST_LD  = AW'(POST_TRIG);
  localparam bit            NO_POST  = (POST_TRIG == 0);

  trace_state_e      state_r, state_next_s;
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r, post_cnt_r, post_next_s;
  logic [AW-1:0]     trig_slot_r, trig_idx_r;
  logic [AW:0]       count_r, remaining_r;
  logic              force_r, rd_valid_r;
  logic              wr_en_s, trig_hit_s, enter_done_s, trig_cond_s, force_s;
  logic [AW:0]       count_inc_s;
  logic [AW-1:0]     wr_ptr_inc_s, oldest_s, trig_slot_s;
  logic [ENTRY_W-1:0] wr_data_s, ram_rd_s;

  assign force_s      = force_r | force_trig;
  assign trig_cond_s  = (trig_en & (cap_pc == trig_pc)) | force_s;
  assign count_inc_s  = (count_r == DEPTH_C) ? count_r : (count_r + CNT_ONE);
  assign wr_ptr_inc_s = wr_ptr_r + PTR_ONE;
  // Once the store has wrapped, the next write slot holds the oldest entry.
  assign oldest_s     = (count_inc_s < DEPTH_C) ? '0 : wr_ptr_inc_s;
  assign trig_slot_s  = (state_r == ST_ARMED) ? wr_ptr_r : trig_slot_r;

  always_comb begin
    wr_data_s = '0;
    wr_data_s[PC_LSB +: DATA_W] = cap_pc;
    wr_data_s[IN_LSB +: DATA_W] = cap_instr;
    wr_data_s[RS_LSB +: DATA_W] = cap_result;
  end

  trace_capture_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_rd_s)
  );

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: arm overrides everything; samples are only written while ARMED/POST.
  always_comb begin
    state_next_s = state_r;
    wr_en_s      = 1'b0;
    trig_hit_s   = 1'b0;
    enter_done_s = 1'b0;
    post_next_s  = post_cnt_r;
    if (arm) begin
      state_next_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (cap_valid) begin
            wr_en_s = 1'b1;
            if (trig_cond_s) begin
              trig_hit_s = 1'b1;
              if (NO_POST) begin
                state_next_s = ST_DONE;
                enter_done_s = 1'b1;
              end else begin
                state_next_s = ST_POST;
                post_next_s  = POST_LD;
              end
            end else begin
              state_next_s = ST_ARMED;
            end
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if (cap_valid) begin
            wr_en_s     = 1'b1;
            post_next_s = post_cnt_r - PTR_ONE;
            if (post_cnt_r == PTR_ONE) begin
              state_next_s = ST_DONE;
              enter_done_s = 1'b1;
            end else begin
              state_next_s = ST_POST;
            end
          end else begin
            state_next_s = ST_POST;
          end
        end
        default: begin
          state_next_s = state_r;
        end
      endcase
    end
  end

  // Pointers, counters, force latch, trigger bookkeeping and read handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      remaining_r <= '0;
      post_cnt_r  <= '0;
      trig_slot_r <= '0;
      trig_idx_r  <= '0;
      force_r     <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else if (arm) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      remaining_r <= '0;
      post_cnt_r  <= '0;
      force_r     <= 1'b0;
      rd_valid_r  <= 1'b0;
    end else begin
      force_r    <= trig_hit_s ? 1'b0 : force_s;
      post_cnt_r <= post_next_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_inc_s;
        count_r  <= count_inc_s;
      end
      if (trig_hit_s) begin
        trig_slot_r <= wr_ptr_r;
      end
      if (enter_done_s) begin
        rd_ptr_r    <= oldest_s;
        remaining_r <= count_inc_s;
        trig_idx_r  <= trig_slot_s - oldest_s;
        rd_valid_r  <= 1'b1;
      end else if (rd_valid_r && rd_ready) begin
        rd_ptr_r    <= rd_ptr_r + PTR_ONE;
        remaining_r <= remaining_r - CNT_ONE;
        if (remaining_r == CNT_ONE) begin
          rd_valid_r <= 1'b0;
        end
      end
    end
  end

  assign state    = state_r;
  assign count    = count_r;
  assign trig_idx = trig_idx_r;
  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_valid_r ? ram_rd_s : '0;
  assign rd_last  = rd_valid_r & (remaining_r == CNT_ONE);

endmodule
